// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet result unloader.
package maxnet_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  // Index width with a floor of one bit so N=1 still has a port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maxnet_result_unloader_snapshot_bank.sv
// N x XLEN snapshot registers: common parallel load, async reset, indexed read.
module snapshot_bank #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [N*XLEN-1:0] d,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [XLEN-1:0]   q
);

  logic [XLEN-1:0] regs [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) regs[i] <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < N; i++) regs[i] <= d[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    q = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rd_idx == IDX_W'(i)) q = regs[i];
    end
  end

endmodule

// File: rtl/maxnet_result_unloader.sv
// Snapshots N neuron activations on start and drains them over valid/ready.
// Optional single-positive winner detection under `MAXNET_WINNER_EN.
module maxnet_result_unloader
  import maxnet_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N*XLEN-1:0] vals_flat,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              done,
  output logic              winner_valid,
  output logic [IDX_W-1:0]  winner_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             load;
  logic             hs;
  logic             at_last;

  assign load     = (state == IDLE) && start;
  assign hs       = out_valid && out_ready;
  assign at_last  = (idx == LAST_IDX);
  assign out_idx  = idx;
  assign out_last = out_valid && at_last;

  snapshot_bank #(
    .XLEN (XLEN),
    .N    (N),
    .IDX_W(IDX_W)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .d     (vals_flat),
    .rd_idx(idx),
    .q     (out_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= SEND;
            idx       <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SEND: begin
          if (hs) begin
            if (at_last) begin
              state     <= DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAXNET_WINNER_EN
  // Positive count saturates at 2: only "exactly one" matters.
  logic [1:0]       pos_cnt;
  logic [IDX_W-1:0] pos_idx;
  logic             word_pos;
  logic [1:0]       cnt_next;
  logic [IDX_W-1:0] pidx_next;

  assign word_pos = hs && !out_data[XLEN-1] && (out_data != '0);

  always_comb begin
    cnt_next  = pos_cnt;
    pidx_next = pos_idx;
    if (word_pos) begin
      cnt_next  = (pos_cnt == 2'd2) ? 2'd2 : pos_cnt + 2'd1;
      pidx_next = idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_cnt      <= '0;
      pos_idx      <= '0;
      winner_valid <= 1'b0;
      winner_idx   <= '0;
    end else if (load) begin
      pos_cnt      <= '0;
      pos_idx      <= '0;
      winner_valid <= 1'b0;
      winner_idx   <= '0;
    end else if (state == SEND && hs) begin
      pos_cnt <= cnt_next;
      pos_idx <= pidx_next;
      if (at_last) begin
        winner_valid <= (cnt_next == 2'd1);
        winner_idx   <= (cnt_next == 2'd1) ? pidx_next : '0;
      end
    end
  end
`else
  assign winner_valid = 1'b0;
  assign winner_idx   = '0;
`endif

endmodule

// File: tb/tb_maxnet_result_unloader.sv
// Scoreboard bench for maxnet_result_unloader (N=4 main instance, N=1 side instance).
module tb_maxnet_result_unloader;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned N     = 4;
  localparam int unsigned IDX_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [N*XLEN-1:0] vals_flat = '0;
  logic              out_ready = 1'b0;
  logic              busy, out_valid, out_last, done, winner_valid;
  logic [XLEN-1:0]   out_data;
  logic [IDX_W-1:0]  out_idx, winner_idx;

  logic              start1 = 1'b0;
  logic [XLEN-1:0]   vals1 = '0;
  logic              ready1 = 1'b0;
  logic              busy1, valid1, last1, done1, wv1;
  logic [XLEN-1:0]   data1;
  logic [0:0]        idx1, widx1;

  always #5 clk = ~clk;

  maxnet_result_unloader #(.XLEN(XLEN), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .vals_flat(vals_flat), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .done(done), .winner_valid(winner_valid), .winner_idx(winner_idx)
  );

  maxnet_result_unloader #(.XLEN(XLEN), .N(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .vals_flat(vals1), .busy(busy1),
    .out_valid(valid1), .out_ready(ready1), .out_data(data1), .out_idx(idx1),
    .out_last(last1), .done(done1), .winner_valid(wv1), .winner_idx(widx1)
  );

  typedef struct {
    logic [XLEN-1:0] data;
    int unsigned     idx;
    bit              last;
  } word_t;

  typedef struct {
    bit          v;
    int unsigned idx;
  } win_t;

  word_t       sb[$];
  win_t        wq[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned ready_mode = 0;
  int unsigned wcnt = 0;
  bit          pend_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: words in neuron order, winner = the sole strictly positive word.
  task automatic expect_drain(input logic [N*XLEN-1:0] v);
    int unsigned npos = 0;
    int unsigned pidx = 0;
    word_t w;
    win_t  r;
    for (int unsigned i = 0; i < N; i++) begin
      w.data = v[i*XLEN +: XLEN];
      w.idx  = i;
      w.last = (i == N - 1);
      sb.push_back(w);
      if ($signed(w.data) > 0) begin
        npos++;
        pidx = i;
      end
    end
    r.v   = (npos == 1);
    r.idx = (npos == 1) ? pidx : 0;
`ifndef MAXNET_WINNER_EN
    r.v   = 1'b0;
    r.idx = 0;
`endif
    wq.push_back(r);
  endtask

  function automatic logic [N*XLEN-1:0] pack4(input int a, input int b, input int c, input int d);
    return {XLEN'(d), XLEN'(c), XLEN'(b), XLEN'(a)};
  endfunction

  function automatic logic [N*XLEN-1:0] rand_vals();
    logic [N*XLEN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0:       r[i*XLEN +: XLEN] = '0;
        1:       r[i*XLEN +: XLEN] = XLEN'($urandom_range(1, 100));
        2:       r[i*XLEN +: XLEN] = -XLEN'($urandom_range(1, 100));
        default: r[i*XLEN +: XLEN] = $urandom();
      endcase
    end
    return r;
  endfunction

  task automatic wait_idle();
    int unsigned t = 0;
    @(negedge clk);
    while (busy && t < 300) begin
      if (!start) vals_flat = rand_vals();
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("wait_idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic drain(input logic [N*XLEN-1:0] v);
    wait_idle();
    start     = 1'b1;
    vals_flat = v;
    @(posedge clk);
    #1;
    start     = 1'b0;
    expect_drain(v);
    vals_flat = rand_vals();
  endtask

  // Monitor: drives out_ready for the cycle and checks against the scoreboard.
  initial begin
    forever begin
      bit nd;
      @(negedge clk);
      nd = 1'b0;
      if (rst) begin
        sb.delete();
        wq.delete();
        pend_done = 1'b0;
        wcnt      = 0;
        out_ready = 1'b0;
      end else begin
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = out_valid && (wcnt == 2);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (out_valid) wcnt = (wcnt == 2) ? 0 : wcnt + 1;
        else wcnt = 0;

        if (sb.size() > 0) begin
          check("valid_no_bubble", 64'(out_valid), 64'(1));
          if (out_valid) begin
            check("out_data", 64'(out_data), 64'(sb[0].data));
            check("out_idx", 64'(out_idx), 64'(sb[0].idx));
            check("out_last", 64'(out_last), 64'(sb[0].last));
            if (out_ready) begin
              nd = sb[0].last;
              void'(sb.pop_front());
            end
          end
        end else begin
          check("no_word_expected", 64'(out_valid), 64'(0));
        end

        if (pend_done || done) begin
          check("done_pulse", 64'(done), 64'(pend_done));
          if (pend_done) begin
            check("busy_in_done", 64'(busy), 64'(1));
            if (wq.size() > 0) begin
              check("winner_valid", 64'(winner_valid), 64'(wq[0].v));
              check("winner_idx", 64'(winner_idx), 64'(wq[0].idx));
              void'(wq.pop_front());
            end else begin
              check("winner_expectation_queue", 64'(wq.size()), 64'(1));
            end
          end
        end
`ifndef MAXNET_WINNER_EN
        check("winner_tied_off", 64'({winner_valid, winner_idx}), 64'(0));
`endif
        pend_done = nd;
      end
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*XLEN-1:0] v;
    logic [XLEN-1:0]   v1;

    // Reset state, both instances
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_idx", 64'(out_idx), 64'(0));
    check("rst_last", 64'(out_last), 64'(0));
    check("rst_winner", 64'({winner_valid, winner_idx}), 64'(0));
    check("rst_n1_outs", 64'({busy1, valid1, last1, done1, wv1, idx1, widx1}), 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;

    // Basic stream at full throughput
    ready_mode = 0;
    drain(pack4(5, 0, -3, 0));

    // Backpressure 0,0,1 per word; vals_flat keeps changing during the drain
    ready_mode = 1;
    drain(rand_vals());
    drain(pack4(-7, 12, 3, -1));

    // Winner cases
    ready_mode = 0;
    drain(pack4(0, 0, 7, 0));
    drain(pack4(1, 0, 7, 0));
    drain(pack4(-2, 0, -9, 4));

    // start held high: restart only after DONE plus one IDLE cycle
    wait_idle();
    v         = pack4(-1, 9, 0, 2);
    start     = 1'b1;
    vals_flat = v;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 0 || k == 6) expect_drain(v);
      if (k == 9) start = 1'b0;
      @(negedge clk);
      check("cont_valid", 64'(out_valid), 64'((k % 6) < 4));
      check("cont_busy", 64'(busy), 64'((k % 6) != 5));
    end

    // Asynchronous reset mid-drain abandons the stream
    wait_idle();
    drain(rand_vals());
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_done_after_rst", 64'(done), 64'(0));
    end

    // Randomized drains with random backpressure
    ready_mode = 2;
    for (int k = 0; k < 12; k++) drain(rand_vals());
    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size() + wq.size()), 64'(0));

    // N=1: single word carries out_last
    v1     = 32'd42;
    start1 = 1'b1;
    vals1  = v1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    vals1  = ~v1;
    @(negedge clk);
    check("n1_word", 64'({valid1, last1, idx1, data1}), 64'({1'b1, 1'b1, 1'b0, v1}));
    @(negedge clk);
    check("n1_hold", 64'({valid1, last1, data1}), 64'({1'b1, 1'b1, v1}));
    ready1 = 1'b1;
    @(negedge clk);
    ready1 = 1'b0;
    check("n1_done", 64'({valid1, done1, busy1}), 64'({1'b0, 1'b1, 1'b1}));
`ifdef MAXNET_WINNER_EN
    check("n1_winner", 64'({wv1, widx1}), 64'({1'b1, 1'b0}));
`else
    check("n1_winner", 64'({wv1, widx1}), 64'(0));
`endif
    @(negedge clk);
    check("n1_idle", 64'({done1, busy1}), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
